regfile_wb: RTL and testbench

- Writeback controller that drives the single write port of the 32x32 integer register file.
- Merges two result sources:
  - the single-cycle ALU result;
  - asynchronous load responses from the LSU, buffered in a small FIFO.
- Emits at most one registered write per cycle.
- Keeps a per-register pending-load scoreboard and drives the decode-stage hazard stall.

---
 rtl/regfile_wb_pkg.sv | 27 ++
 rtl/regfile_wb_chk.sv | 19 +
 rtl/wb_ld_fifo.sv | 47 ++++
 rtl/regfile_wb.sv | 160 ++++++++++++++++
 tb/tb_regfile_wb.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback controller.
// Build option REGFILE_WB_BYPASS_EN is consumed by regfile_wb.sv.
package regfile_wb_pkg;

   localparam int REG_NUM = 32;
   localparam int REG_AW  = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd_addr;
      logic [31:0]       data;
   } wb_req_t;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LD  = 1'b1
   } wb_src_e;

   // One-hot register decode; x0 never maps to a scoreboard bit.
   function automatic logic [REG_NUM-1:0] reg_dec(input logic [REG_AW-1:0] addr);
      logic [REG_NUM-1:0] oh;
      oh       = '0;
      oh[addr] = 1'b1;
      oh[0]    = 1'b0;
      return oh;
   endfunction

endpackage

// File: rtl/regfile_wb_chk.sv
// Protocol checks for regfile_wb: no ALU result during hold, no ALU write to a pending load target.
module regfile_wb_chk
   import regfile_wb_pkg::*;
(
   input logic               clk,
   input logic               rst,
   input logic               alu_valid,
   input logic [REG_AW-1:0]  alu_rd_addr,
   input logic               alu_hold,
   input logic [REG_NUM-1:0] pend
);

   a_no_alu_during_hold: assert property (@(posedge clk) disable iff (!rst)
      !(alu_valid && alu_hold));

   a_no_alu_to_pending: assert property (@(posedge clk) disable iff (!rst)
      !(alu_valid && pend[alu_rd_addr]));

endmodule

// File: rtl/wb_ld_fifo.sv
// Load-response buffer: power-of-two depth, extra pointer bit tells full from empty.
module wb_ld_fifo
   import regfile_wb_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int PW = $clog2(DEPTH);

   wb_req_t       mem_r [DEPTH];
   logic [PW:0]   wptr_r;
   logic [PW:0]   rptr_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign empty     = (wptr_r == rptr_r);
   assign full      = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
   assign head      = mem_r[rptr_r[PW-1:0]];

   // Read/write pointers; reset discards any buffered responses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else begin
         if (do_push_s) wptr_r <= wptr_r + 1'b1;
         if (do_pop_s)  rptr_r <= rptr_r + 1'b1;
      end
   end

   // Payload storage; contents are meaningless while empty so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wptr_r[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/regfile_wb.sv
// Writeback arbiter (ALU vs buffered loads), starvation guard and load scoreboard.
// Build option REGFILE_WB_BYPASS_EN: stall ignores a pending reg being written by a load this cycle.
module regfile_wb
   import regfile_wb_pkg::*;
#(
   parameter int LD_BUF_DEPTH = 2,
   parameter int STARVE_MAX   = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_alu_valid,
   input  logic [REG_AW-1:0] i_alu_rd_addr,
   input  logic [31:0]       i_alu_rd_data,
   output logic              o_alu_hold,
   input  logic              i_ld_issue,
   input  logic [REG_AW-1:0] i_ld_issue_rd,
   input  logic              i_ld_valid,
   output logic              o_ld_ready,
   input  logic [REG_AW-1:0] i_ld_rd_addr,
   input  logic [31:0]       i_ld_data,
   output logic              o_rd_wr,
   output logic [REG_AW-1:0] o_rd_addr,
   output logic [31:0]       o_rd_data,
   input  logic [REG_AW-1:0] i_rs1_addr,
   input  logic [REG_AW-1:0] i_rs2_addr,
   input  logic [REG_AW-1:0] i_chk_rd,
   output logic              o_stall
);

   localparam int                 CW       = $clog2(STARVE_MAX) + 1;
   localparam logic [CW-1:0]      CNT_LAST = CW'(STARVE_MAX - 1);

   wb_req_t             ld_req_s;
   wb_req_t             head_s;
   wb_req_t             win_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic                sel_alu_s;
   logic                sel_ld_s;
   logic                rd_wr_r;
   logic [REG_AW-1:0]   rd_addr_r;
   logic [31:0]         rd_data_r;
   wb_src_e             src_r;
   logic                src_ld_s;
   logic [CW-1:0]       starve_cnt_r;
   logic                hold_r;
   logic [REG_NUM-1:0]  pend_r;
   logic [REG_NUM-1:0]  sb_set_s;
   logic [REG_NUM-1:0]  sb_clr_s;
   logic [REG_NUM-1:0]  vis_s;

   assign ld_req_s.rd_addr = i_ld_rd_addr;
   assign ld_req_s.data    = i_ld_data;
   assign o_ld_ready       = !fifo_full_s;
   assign src_ld_s         = (src_r == WB_SRC_LD);

   wb_ld_fifo #(.DEPTH(LD_BUF_DEPTH)) u_ld_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (i_ld_valid),
      .push_data (ld_req_s),
      .pop       (sel_ld_s),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Fixed-priority arbitration: ALU first, then FIFO head.
   always_comb begin
      sel_alu_s = 1'b0;
      sel_ld_s  = 1'b0;
      win_s     = '0;
      if (i_alu_valid) begin
         sel_alu_s     = 1'b1;
         win_s.rd_addr = i_alu_rd_addr;
         win_s.data    = i_alu_rd_data;
      end else if (!fifo_empty_s) begin
         sel_ld_s = 1'b1;
         win_s    = head_s;
      end else begin
         win_s = '0;
      end
   end

   // Registered write port; x0 destinations are consumed but never written.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_wr_r   <= 1'b0;
         rd_addr_r <= '0;
         rd_data_r <= 32'h0000_0000;
         src_r     <= WB_SRC_ALU;
      end else if (sel_alu_s || sel_ld_s) begin
         rd_wr_r   <= (win_s.rd_addr != 5'd0);
         rd_addr_r <= win_s.rd_addr;
         rd_data_r <= win_s.data;
         src_r     <= sel_ld_s ? WB_SRC_LD : WB_SRC_ALU;
      end else begin
         rd_wr_r <= 1'b0;
      end
   end

   // Starvation guard: the counter saturates at its last value until a pop frees the head.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt_r <= '0;
         hold_r       <= 1'b0;
      end else begin
         hold_r <= 1'b0;
         if (fifo_empty_s || sel_ld_s) begin
            starve_cnt_r <= '0;
         end else if (sel_alu_s) begin
            if (starve_cnt_r == CNT_LAST) hold_r <= 1'b1;
            else                          starve_cnt_r <= starve_cnt_r + 1'b1;
         end
      end
   end

   // Scoreboard set/clear masks; a load leaving the write port clears its bit.
   always_comb begin
      sb_set_s = '0;
      sb_clr_s = '0;
      if (i_ld_issue) sb_set_s = reg_dec(i_ld_issue_rd);
      else            sb_set_s = '0;
      if (rd_wr_r && src_ld_s) sb_clr_s = reg_dec(rd_addr_r);
      else                     sb_clr_s = '0;
   end

   // Pending-load scoreboard; a new issue beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst) pend_r <= '0;
      else      pend_r <= (pend_r & ~sb_clr_s) | sb_set_s;
   end

   // Decode hazard stall.
   always_comb begin
      vis_s = pend_r;
`ifdef REGFILE_WB_BYPASS_EN
      if (rd_wr_r && src_ld_s) vis_s = pend_r & ~sb_clr_s;
      else                     vis_s = pend_r;
`else
      vis_s = pend_r;
`endif
      o_stall = vis_s[i_rs1_addr] | vis_s[i_rs2_addr] | vis_s[i_chk_rd];
   end

   assign o_rd_wr    = rd_wr_r;
   assign o_rd_addr  = rd_addr_r;
   assign o_rd_data  = rd_data_r;
   assign o_alu_hold = hold_r;

   regfile_wb_chk u_chk (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (i_alu_valid),
      .alu_rd_addr (i_alu_rd_addr),
      .alu_hold    (hold_r),
      .pend        (pend_r)
   );

endmodule

// File: tb/tb_regfile_wb.sv
// Table-driven bench for regfile_wb: each vector is held across one clock edge
// and outputs are compared 1 time unit after that edge.
module tb_regfile_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_alu_valid;
   logic [4:0]  i_alu_rd_addr;
   logic [31:0] i_alu_rd_data;
   logic        o_alu_hold;
   logic        i_ld_issue;
   logic [4:0]  i_ld_issue_rd;
   logic        i_ld_valid;
   logic        o_ld_ready;
   logic [4:0]  i_ld_rd_addr;
   logic [31:0] i_ld_data;
   logic        o_rd_wr;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic [4:0]  i_rs1_addr;
   logic [4:0]  i_rs2_addr;
   logic [4:0]  i_chk_rd;
   logic        o_stall;

   int vectors_applied = 0;
   int miscompares     = 0;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      bit        av;   bit [4:0] ard;  bit [31:0] adat;
      bit        li;   bit [4:0] lird;
      bit        lv;   bit [4:0] lrd;  bit [31:0] ldat;
      bit [4:0]  rs1;  bit [4:0] rs2;  bit [4:0]  chk;
      bit        ewr;  bit [4:0] eaddr; bit [31:0] edata;
      bit        erdy; bit estl; bit estlb; bit ehold;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];

   regfile_wb dut (
      .clk           (clk),
      .rst           (rst),
      .i_alu_valid   (i_alu_valid),
      .i_alu_rd_addr (i_alu_rd_addr),
      .i_alu_rd_data (i_alu_rd_data),
      .o_alu_hold    (o_alu_hold),
      .i_ld_issue    (i_ld_issue),
      .i_ld_issue_rd (i_ld_issue_rd),
      .i_ld_valid    (i_ld_valid),
      .o_ld_ready    (o_ld_ready),
      .i_ld_rd_addr  (i_ld_rd_addr),
      .i_ld_data     (i_ld_data),
      .o_rd_wr       (o_rd_wr),
      .o_rd_addr     (o_rd_addr),
      .o_rd_data     (o_rd_data),
      .i_rs1_addr    (i_rs1_addr),
      .i_rs2_addr    (i_rs2_addr),
      .i_chk_rd      (i_chk_rd),
      .o_stall       (o_stall)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input bit av, input bit [4:0] ard, input bit [31:0] adat,
      input bit li, input bit [4:0] lird,
      input bit lv, input bit [4:0] lrd, input bit [31:0] ldat,
      input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] chk,
      input bit ewr, input bit [4:0] eaddr, input bit [31:0] edata,
      input bit erdy, input bit estl, input bit estlb, input bit ehold);
      vec_t v;
      v.av = av; v.ard = ard; v.adat = adat;
      v.li = li; v.lird = lird;
      v.lv = lv; v.lrd = lrd; v.ldat = ldat;
      v.rs1 = rs1; v.rs2 = rs2; v.chk = chk;
      v.ewr = ewr; v.eaddr = eaddr; v.edata = edata;
      v.erdy = erdy; v.estl = estl; v.estlb = estlb; v.ehold = ehold;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      i_alu_valid   = v.av;  i_alu_rd_addr = v.ard;  i_alu_rd_data = v.adat;
      i_ld_issue    = v.li;  i_ld_issue_rd = v.lird;
      i_ld_valid    = v.lv;  i_ld_rd_addr  = v.lrd;  i_ld_data     = v.ldat;
      i_rs1_addr    = v.rs1; i_rs2_addr    = v.rs2;  i_chk_rd      = v.chk;
   endtask

   task automatic check_outs(input string tag, input bit ewr, input bit [4:0] eaddr,
                             input bit [31:0] edata, input bit erdy, input bit estl,
                             input bit ehold);
      vectors_applied++;
      chk({tag, " rd_wr"}, {31'd0, o_rd_wr}, {31'd0, ewr});
      if (ewr) begin
         chk({tag, " rd_addr"}, {27'd0, o_rd_addr}, {27'd0, eaddr});
         chk({tag, " rd_data"}, o_rd_data, edata);
      end
      chk({tag, " ld_ready"}, {31'd0, o_ld_ready}, {31'd0, erdy});
      chk({tag, " stall"},    {31'd0, o_stall},    {31'd0, estl});
      chk({tag, " alu_hold"}, {31'd0, o_alu_hold}, {31'd0, ehold});
   endtask

   initial begin
      vec_t idle;
      //            av ard    adat           li lird  lv lrd   ldat          rs1   rs2   chk    wr addr  data          rdy stl stlb hold
      vecs[0]  = mk(1, 5'd5,  32'hDEADBEEF,  0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  1, 5'd5, 32'hDEADBEEF, 1, 0, 0, 0);
      vecs[1]  = mk(1, 5'd0,  32'h11111111,  0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 0, 0, 0);
      vecs[2]  = mk(0, 5'd0,  32'h0,         1, 5'd7, 0, 5'd0, 32'h0,        5'd7, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 1, 0);
      vecs[3]  = mk(0, 5'd0,  32'h0,         0, 5'd0, 1, 5'd7, 32'h1234,     5'd7, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 1, 0);
      vecs[4]  = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd7, 5'd0, 5'd0,  1, 5'd7, 32'h1234,     1, 1, 0, 0);
      vecs[5]  = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd7, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 0, 0, 0);
      vecs[6]  = mk(1, 5'd1,  32'hA1,        0, 5'd0, 1, 5'd9, 32'h99,       5'd0, 5'd0, 5'd0,  1, 5'd1, 32'hA1,       1, 0, 0, 0);
      vecs[7]  = mk(1, 5'd2,  32'hA2,        0, 5'd0, 1, 5'd10, 32'hAA,      5'd0, 5'd0, 5'd0,  1, 5'd2, 32'hA2,       0, 0, 0, 0);
      vecs[8]  = mk(1, 5'd3,  32'hA3,        0, 5'd0, 1, 5'd11, 32'hBB,      5'd0, 5'd0, 5'd0,  1, 5'd3, 32'hA3,       0, 0, 0, 0);
      vecs[9]  = mk(1, 5'd4,  32'hA4,        0, 5'd0, 1, 5'd11, 32'hBB,      5'd0, 5'd0, 5'd0,  1, 5'd4, 32'hA4,       0, 0, 0, 0);
      vecs[10] = mk(1, 5'd5,  32'hA5,        0, 5'd0, 1, 5'd11, 32'hBB,      5'd0, 5'd0, 5'd0,  1, 5'd5, 32'hA5,       0, 0, 0, 1);
      vecs[11] = mk(0, 5'd0,  32'h0,         0, 5'd0, 1, 5'd11, 32'hBB,      5'd0, 5'd0, 5'd0,  1, 5'd9, 32'h99,       1, 0, 0, 0);
      vecs[12] = mk(1, 5'd6,  32'hA6,        0, 5'd0, 1, 5'd11, 32'hBB,      5'd0, 5'd0, 5'd0,  1, 5'd6, 32'hA6,       0, 0, 0, 0);
      vecs[13] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  1, 5'd10, 32'hAA,      1, 0, 0, 0);
      vecs[14] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  1, 5'd11, 32'hBB,      1, 0, 0, 0);
      vecs[15] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 0, 0, 0);
      vecs[16] = mk(0, 5'd0,  32'h0,         1, 5'd3, 0, 5'd0, 32'h0,        5'd0, 5'd3, 5'd0,  0, 5'd0, 32'h0,        1, 1, 1, 0);
      vecs[17] = mk(0, 5'd0,  32'h0,         0, 5'd0, 1, 5'd3, 32'h33,       5'd0, 5'd3, 5'd0,  0, 5'd0, 32'h0,        1, 1, 1, 0);
      vecs[18] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd3, 5'd0,  1, 5'd3, 32'h33,       1, 1, 0, 0);
      vecs[19] = mk(0, 5'd0,  32'h0,         1, 5'd3, 0, 5'd0, 32'h0,        5'd0, 5'd3, 5'd0,  0, 5'd0, 32'h0,        1, 1, 1, 0);
      vecs[20] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd3, 5'd0,  0, 5'd0, 32'h0,        1, 1, 1, 0);
      vecs[21] = mk(0, 5'd0,  32'h0,         0, 5'd0, 1, 5'd0, 32'h55,       5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 0, 0, 0);
      vecs[22] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 0, 0, 0);
      vecs[23] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd3,  0, 5'd0, 32'h0,        1, 1, 1, 0);
      vecs[24] = mk(0, 5'd0,  32'h0,         0, 5'd0, 1, 5'd8, 32'h88,       5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 0, 0, 0);
      vecs[25] = mk(0, 5'd0,  32'h0,         0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  1, 5'd8, 32'h88,       1, 0, 0, 0);

      idle = mk(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 0, 0, 0);

      rst = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("reset rd_addr", {27'd0, o_rd_addr}, 32'h0);
      chk("reset rd_data", o_rd_data, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].eaddr, vecs[i].edata,
                    vecs[i].erdy, BYP ? vecs[i].estlb : vecs[i].estl, vecs[i].ehold);
      end

      // Reset with two buffered responses and pending bits for x3 and x12.
      drive(mk(1, 5'd1, 32'hC1, 1, 5'd12, 1, 5'd12, 32'hCC, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_outs("mid_a", 1'b1, 5'd1, 32'hC1, 1'b1, 1'b0, 1'b0);
      drive(mk(1, 5'd2, 32'hC2, 0, 5'd0, 1, 5'd13, 32'hDD, 5'd12, 5'd3, 5'd0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_outs("mid_b", 1'b1, 5'd2, 32'hC2, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      drive(mk(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd12, 5'd3, 5'd0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_outs("rst_mid", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("rst_mid rd_addr", {27'd0, o_rd_addr}, 32'h0);
      chk("rst_mid rd_data", o_rd_data, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_outs("post_rst", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outs("post_rst2", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
